// File: rtl/adder8_inv_serial.sv
// Bit-serial inverse of the 8-bit adder: recovers in2 = res - in1 one bit per clock, LSB first,
// and flags results that could not have come from a legal W-bit addition (borrow / ovf).
module adder8_inv_serial #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W:0]   res,
  input  logic [W-1:0] in1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] in2,
  output logic         borrow,
  output logic         ovf,
  output logic [1:0]   state_dbg
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
  // valid must then be held until that edge, and ready never depends combinationally on valid.

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [W:0]    r_sh;
  logic [W:0]    a_sh;
  logic [W:0]    d_sh;
  logic          b;
  logic [CW-1:0] cnt;

  logic          d_bit;
  logic          b_nx;
  logic [W:0]    d_sh_nx;
  logic          last_bit;
  logic          accept;
  logic          release_out;

  assign start_ready = (state == IDLE);
  assign state_dbg   = state;
  assign accept      = start_valid && (state == IDLE);
  assign release_out = out_ready && (state == DONE);
  assign last_bit    = (cnt == CW'(W));

  // Full-subtractor cell operating on the current LSBs.
  always_comb begin
    d_bit   = r_sh[0] ^ a_sh[0] ^ b;
    b_nx    = (~r_sh[0] & a_sh[0]) | (~(r_sh[0] ^ a_sh[0]) & b);
    d_sh_nx = {d_bit, d_sh[W:1]};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_valid) state_nx = RUN;
      RUN:  if (last_bit)    state_nx = DONE;
      DONE: if (out_ready)   state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh <= '0;
      a_sh <= '0;
      d_sh <= '0;
      b    <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      r_sh <= res;
      a_sh <= {1'b0, in1};
      d_sh <= '0;
      b    <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      r_sh <= {1'b0, r_sh[W:1]};
      a_sh <= {1'b0, a_sh[W:1]};
      d_sh <= d_sh_nx;
      b    <= b_nx;
      if (!last_bit) cnt <= cnt + 1'b1;
    end
  end

  // Result registers load from the final-bit values so they are valid together with out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      in2       <= '0;
      borrow    <= 1'b0;
      ovf       <= 1'b0;
    end else if ((state == RUN) && last_bit) begin
      out_valid <= 1'b1;
      in2       <= d_sh_nx[W-1:0];
      borrow    <= b_nx;
      ovf       <= d_sh_nx[W] & ~b_nx;
    end else if (release_out) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder8_inv_serial.sv
// Directed and randomized checks of adder8_inv_serial against hand-computed subtraction results.
module tb_adder8_inv_serial;

  logic       clk;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [8:0] res;
  logic [7:0] in1;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in2;
  logic       borrow;
  logic       ovf;
  logic [1:0] state_dbg;

  int checks;
  int failures;

  adder8_inv_serial #(.W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .res         (res),
    .in1         (in1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .in2         (in2),
    .borrow      (borrow),
    .ovf         (ovf),
    .state_dbg   (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present a request, return latency (edges from acceptance to out_valid).
  task automatic issue(input logic [8:0] r, input logic [7:0] a, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!start_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    res = r;
    in1 = a;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    res = ~r;
    in1 = ~a;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_valid = 1'b0;
    out_ready = 1'b0;
    res = '0;
    in1 = '0;
    #1;
    checks++;
    if (start_ready !== 1'b1 || out_valid !== 1'b0 || in2 !== 8'h00 || borrow !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset: ready=%b valid=%b in2=%h borrow=%b ovf=%b expected 1 0 00 0 0",
               start_ready, out_valid, in2, borrow, ovf);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle: ready=%b valid=%b expected 1 0", start_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [8:0] r_t [4];
    logic [7:0] a_t [4];
    logic [7:0] e_in2 [4];
    logic       e_b [4];
    logic       e_o [4];
    int lat;
    r_t[0] = 9'h0FF; a_t[0] = 8'h55; e_in2[0] = 8'hAA; e_b[0] = 1'b0; e_o[0] = 1'b0;
    r_t[1] = 9'h1FE; a_t[1] = 8'hFF; e_in2[1] = 8'hFF; e_b[1] = 1'b0; e_o[1] = 1'b0;
    r_t[2] = 9'h003; a_t[2] = 8'h05; e_in2[2] = 8'hFE; e_b[2] = 1'b1; e_o[2] = 1'b0;
    r_t[3] = 9'h180; a_t[3] = 8'h10; e_in2[3] = 8'h70; e_b[3] = 1'b0; e_o[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(r_t[i], a_t[i], lat);
      checks++;
      if (lat !== 9) begin
        failures++;
        $display("FAIL latency[%0d]: got %0d expected 9", i, lat);
      end
      checks++;
      if (in2 !== e_in2[i] || borrow !== e_b[i] || ovf !== e_o[i]) begin
        failures++;
        $display("FAIL result[%0d]: in2=%h borrow=%b ovf=%b expected %h %b %b",
                 i, in2, borrow, ovf, e_in2[i], e_b[i], e_o[i]);
      end
      handshake();
      checks++;
      if (out_valid !== 1'b0 || in2 !== e_in2[i]) begin
        failures++;
        $display("FAIL release[%0d]: valid=%b in2=%h expected 0 %h", i, out_valid, in2, e_in2[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(9'h180, 8'h10, lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || start_ready !== 1'b0 || in2 !== 8'h70 || borrow !== 1'b0 || ovf !== 1'b1) begin
        failures++;
        $display("FAIL hold[%0d]: valid=%b ready=%b in2=%h borrow=%b ovf=%b expected 1 0 70 0 1",
                 k, out_valid, start_ready, in2, borrow, ovf);
      end
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(9'h0FF, 8'h55, lat);
    @(negedge clk);
    start_valid = 1'b1;
    res = 9'h003;
    in1 = 8'h05;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_accept_on_release: ready=%b valid=%b expected 1 0", start_ready, out_valid);
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 9 || in2 !== 8'hFE || borrow !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back: lat=%0d in2=%h borrow=%b ovf=%b expected 9 fe 1 0", lat, in2, borrow, ovf);
    end
    handshake();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    res = 9'h1FE;
    in1 = 8'hFF;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || start_ready !== 1'b1 || in2 !== 8'h00) begin
      failures++;
      $display("FAIL mid_run_reset: valid=%b ready=%b in2=%h expected 0 1 00", out_valid, start_ready, in2);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL aborted_output: valid=%b expected 0", out_valid);
    end
    issue(9'h0FF, 8'h55, lat);
    checks++;
    if (lat !== 9 || in2 !== 8'hAA || borrow !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: lat=%0d in2=%h borrow=%b ovf=%b expected 9 aa 0 0", lat, in2, borrow, ovf);
    end
    handshake();
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] bv;
    logic [8:0] s;
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int lat;
    for (int i = 0; i < 1500; i++) begin
      a = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      s = {1'b0, a} + {1'b0, bv};
      exp_q.push_back(bv);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(s, a, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (lat !== 9 || in2 !== e || borrow !== 1'b0 || ovf !== 1'b0) begin
        failures++;
        $display("FAIL random[%0d]: res=%h in1=%h lat=%0d in2=%h borrow=%b ovf=%b expected 9 %h 0 0",
                 i, s, a, lat, in2, borrow, ovf, e);
      end
      handshake();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
